// File: rtl/i2s_tx_serializer_if.sv
// Control, sample and I2S signal bundle for i2s_tx_serializer.
interface i2s_tx_serializer_if #(
    parameter int unsigned DATA_W = 24
);
    logic              audio_en;
    logic              l_data_en;
    logic              r_data_en;
    logic [DATA_W-1:0] l_data;
    logic [DATA_W-1:0] r_data;
    logic              status_clr;
    logic              bclk;
    logic              lrclk;
    logic              s_data;
    logic              sample_req;
    logic [3:0]        status;

    // Sample source / controller side.
    modport master (
        output audio_en, l_data_en, r_data_en, l_data, r_data, status_clr,
        input  bclk, lrclk, s_data, sample_req, status
    );

    // Serializer side.
    modport slave (
        input  audio_en, l_data_en, r_data_en, l_data, r_data, status_clr,
        output bclk, lrclk, s_data, sample_req, status
    );
endinterface

// File: rtl/i2s_tx_serializer.sv
// I2S transmitter: double-buffered L/R samples serialized into 64-bclk frames.
module i2s_tx_serializer #(
    parameter int unsigned BCLK_DIV = 4,
    parameter int unsigned DATA_W   = 24
) (
    input logic                clk,
    input logic                reset,
    i2s_tx_serializer_if.slave bus
);
    localparam int unsigned    HcW   = (BCLK_DIV > 2) ? $clog2(BCLK_DIV) : 1;
    localparam logic [HcW-1:0] HcMax = HcW'(BCLK_DIV - 1);

    typedef enum logic [0:0] {StIdle, StRun} state_e;

    state_e            state_q, state_d;
    logic [HcW-1:0]    hc_q, hc_d;
    logic [5:0]        bc_q, bc_d;
    logic              bclk_q, bclk_d;
    logic              lrclk_q, lrclk_d;
    logic              sdata_q, sdata_d;
    logic              sample_req_q, sample_req_d;
    logic [1:0]        status_q, status_d;
    logic [DATA_W-1:0] hold_l_q, hold_l_d, hold_r_q, hold_r_d;
    logic              full_l_q, full_l_d, full_r_q, full_r_d;
    logic [DATA_W-1:0] frame_l_q, frame_l_d, frame_r_q, frame_r_d;

    logic              load;
    logic              underrun_set;
    logic              overrun_set;
    logic [4:0]        slot;
    logic [DATA_W-1:0] word;
    logic [DATA_W-1:0] shifted;

    // Next-state: bit clock generation, frame sequencing, sample buffering, status.
    always_comb begin
        state_d      = state_q;
        hc_d         = hc_q;
        bc_d         = bc_q;
        bclk_d       = bclk_q;
        lrclk_d      = lrclk_q;
        sdata_d      = sdata_q;
        hold_l_d     = hold_l_q;
        hold_r_d     = hold_r_q;
        full_l_d     = full_l_q;
        full_r_d     = full_r_q;
        frame_l_d    = frame_l_q;
        frame_r_d    = frame_r_q;
        load         = 1'b0;
        underrun_set = 1'b0;
        overrun_set  = 1'b0;
        slot         = '0;
        word         = '0;
        shifted      = '0;

        if (!bus.audio_en) begin
            // Abort immediately; buffered samples survive the pause.
            state_d = StIdle;
            hc_d    = '0;
            bc_d    = '0;
            bclk_d  = 1'b0;
            lrclk_d = 1'b0;
            sdata_d = 1'b0;
        end else begin
            state_d = StRun;
            unique case (state_q)
                // Counters and outputs are already zero here, so the first
                // running cycle is bc=0 and simply loads a frame.
                StIdle: load = 1'b1;
                StRun: begin
                    if (hc_q == HcMax) begin
                        hc_d   = '0;
                        bclk_d = ~bclk_q;
                        if (bclk_q) begin
                            // Falling edge: advance the bit and present it.
                            bc_d    = bc_q + 6'd1;
                            lrclk_d = bc_d[5];
                            slot    = bc_d[4:0];
                            word    = bc_d[5] ? frame_r_q : frame_l_q;
                            shifted = word << (slot - 5'd1);
                            sdata_d = (slot != 5'd0) && (32'(slot) <= DATA_W) ?
                                      shifted[DATA_W-1] : 1'b0;
                            load    = (bc_q == 6'd63);
                        end
                    end else begin
                        hc_d = hc_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end

        if (load) begin
            // A strobe in the load cycle bypasses straight into the frame.
            frame_l_d    = bus.l_data_en ? bus.l_data : hold_l_q;
            frame_r_d    = bus.r_data_en ? bus.r_data : hold_r_q;
            full_l_d     = 1'b0;
            full_r_d     = 1'b0;
            underrun_set = (!full_l_q && !bus.l_data_en) || (!full_r_q && !bus.r_data_en);
        end

        // Hold also takes bypassed data, so an underrun repeats the newest sample.
        if (bus.l_data_en) begin
            hold_l_d = bus.l_data;
            if (!load) full_l_d = 1'b1;
        end
        if (bus.r_data_en) begin
            hold_r_d = bus.r_data;
            if (!load) full_r_d = 1'b1;
        end
        overrun_set = (bus.l_data_en && full_l_q) || (bus.r_data_en && full_r_q);

        // Set events win over a simultaneous clear.
        status_d     = (status_q & ~{2{bus.status_clr}}) | {overrun_set, underrun_set};
        sample_req_d = load;
    end

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= StIdle;
            hc_q         <= '0;
            bc_q         <= '0;
            bclk_q       <= 1'b0;
            lrclk_q      <= 1'b0;
            sdata_q      <= 1'b0;
            sample_req_q <= 1'b0;
            status_q     <= '0;
            hold_l_q     <= '0;
            hold_r_q     <= '0;
            full_l_q     <= 1'b0;
            full_r_q     <= 1'b0;
            frame_l_q    <= '0;
            frame_r_q    <= '0;
        end else begin
            state_q      <= state_d;
            hc_q         <= hc_d;
            bc_q         <= bc_d;
            bclk_q       <= bclk_d;
            lrclk_q      <= lrclk_d;
            sdata_q      <= sdata_d;
            sample_req_q <= sample_req_d;
            status_q     <= status_d;
            hold_l_q     <= hold_l_d;
            hold_r_q     <= hold_r_d;
            full_l_q     <= full_l_d;
            full_r_q     <= full_r_d;
            frame_l_q    <= frame_l_d;
            frame_r_q    <= frame_r_d;
        end
    end

    assign bus.bclk       = bclk_q;
    assign bus.lrclk      = lrclk_q;
    assign bus.s_data     = sdata_q;
    assign bus.sample_req = sample_req_q;
    assign bus.status     = {1'b0, (state_q == StRun), status_q};
endmodule

// File: tb/tb_i2s_tx_serializer.sv
// Bench for i2s_tx_serializer: time-based frame model, serial decoder, directed scenarios.
module tb_i2s_tx_serializer;
    localparam int unsigned D = 4;
    localparam int unsigned W = 24;
    localparam int FrameClk = 128 * D;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    i2s_tx_serializer_if #(.DATA_W(W)) bus ();

    i2s_tx_serializer #(
        .BCLK_DIV(D),
        .DATA_W  (W)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    // Model state: time since the first running cycle plus buffered samples.
    bit         m_run = 1'b0;
    bit         m_load = 1'b0;
    int         m_t = 0;
    bit         m_lfull = 1'b0, m_rfull = 1'b0;
    logic [W-1:0] m_lhold = '0, m_rhold = '0, m_fl = '0, m_fr = '0;
    logic [1:0] m_stat = '0;
    bit         lf0, rf0, uf, of;

    // Model advances on every rising edge using the inputs held over that edge.
    initial forever begin
        @(posedge clk);
        if (reset) begin
            m_run = 0; m_load = 0; m_t = 0; m_lfull = 0; m_rfull = 0;
            m_lhold = '0; m_rhold = '0; m_fl = '0; m_fr = '0; m_stat = '0;
        end else begin
            m_load = 0;
            if (bus.audio_en) begin
                if (!m_run) begin
                    m_run = 1;
                    m_t   = 0;
                end else begin
                    m_t++;
                end
                m_load = (m_t % FrameClk) == 0;
            end else begin
                m_run = 0;
            end
            lf0 = m_lfull;
            rf0 = m_rfull;
            uf  = 0;
            if (m_load) begin
                uf = (!lf0 && !bus.l_data_en) || (!rf0 && !bus.r_data_en);
                m_fl = bus.l_data_en ? bus.l_data : m_lhold;
                m_fr = bus.r_data_en ? bus.r_data : m_rhold;
                m_lfull = 0;
                m_rfull = 0;
            end
            of = (bus.l_data_en && lf0) || (bus.r_data_en && rf0);
            if (bus.l_data_en) begin m_lhold = bus.l_data; m_lfull = !m_load; end
            if (bus.r_data_en) begin m_rhold = bus.r_data; m_rfull = !m_load; end
            m_stat = (m_stat & ~{2{bus.status_clr}}) | {of, uf};
        end
    end

    // Compare every cycle on the falling clk edge.
    int           e_half, e_bc, e_k;
    logic [W-1:0] e_word, e_tmp;
    logic         e_sd, e_bclk, e_lr;
    logic [7:0]   e_vec, a_vec;
    initial forever begin
        @(negedge clk);
        if (m_run) begin
            e_half = m_t / D;
            e_bc   = (e_half / 2) % 64;
            e_k    = e_bc % 32;
            e_lr   = e_bc >= 32;
            e_bclk = (e_half % 2) == 1;
            e_word = e_lr ? m_fr : m_fl;
            e_tmp  = e_word >> (W - e_k);
            e_sd   = (e_k >= 1 && e_k <= W) ? e_tmp[0] : 1'b0;
        end else begin
            e_lr = 0; e_bclk = 0; e_sd = 0;
        end
        e_vec = {e_bclk, e_lr, e_sd, m_load, 1'b0, m_run, m_stat};
        a_vec = {bus.bclk, bus.lrclk, bus.s_data, bus.sample_req, bus.status};
        check("cycle", 32'(a_vec), 32'(e_vec));
    end

    // Serial decoder: recovers the last complete L and R words from the pins.
    logic [W-1:0] last_l = '0, last_r = '0, d_word = '0;
    int           d_n = 0;
    logic         d_prev_lr = 0, d_prev_bclk = 0;
    initial forever begin
        @(negedge clk);
        if (bus.status[2] !== 1'b1) begin
            d_n = 0; d_word = '0; d_prev_lr = 0; d_prev_bclk = 0;
        end else begin
            if (bus.lrclk != d_prev_lr) begin
                if (d_prev_lr) last_r = d_word;
                else last_l = d_word;
                d_word = '0;
                d_n    = 0;
            end
            if (bus.bclk && !d_prev_bclk) begin
                if (d_n >= 1 && d_n <= W) d_word = {d_word[W-2:0], bus.s_data};
                d_n++;
            end
            d_prev_lr   = bus.lrclk;
            d_prev_bclk = bus.bclk;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic strobe(input bit dl, input bit dr, input logic [W-1:0] l, input logic [W-1:0] r);
        bus.l_data_en = dl;
        bus.r_data_en = dr;
        bus.l_data    = l;
        bus.r_data    = r;
        tick(1);
        bus.l_data_en = 0;
        bus.r_data_en = 0;
    endtask

    task automatic clr_pulse();
        bus.status_clr = 1;
        tick(1);
        bus.status_clr = 0;
    endtask

    // Wait for the next frame load (bounded), then step 2 cycles past it.
    task automatic wait_load();
        int n;
        n = 0;
        while (bus.sample_req !== 1'b1 && n < 2 * FrameClk) begin
            tick(1);
            n++;
        end
        if (n >= 2 * FrameClk) check("wait_load_timeout", 32'd0, 32'd1);
        tick(2);
    endtask

    initial begin
        reset          = 1;
        bus.audio_en   = 0;
        bus.l_data_en  = 0;
        bus.r_data_en  = 0;
        bus.l_data     = '0;
        bus.r_data     = '0;
        bus.status_clr = 0;
        tick(3);
        check("reset_outputs", 32'({bus.bclk, bus.lrclk, bus.s_data, bus.sample_req}), 32'd0);
        check("reset_status", 32'(bus.status), 32'd0);
        reset = 0;
        tick(2);

        // Steady stream with a fresh sample pair every frame.
        strobe(1, 1, 24'hA5F00F, 24'h5A0FF0);
        bus.audio_en = 1;
        for (int f = 0; f < 3; f++) begin
            wait_load();
            tick(100);
            strobe(1, 1, 24'hA5F00F, 24'h5A0FF0);
        end
        wait_load();
        check("stream_l", 32'(last_l), 32'hA5F00F);
        check("stream_r", 32'(last_r), 32'h5A0FF0);
        check("stream_status", 32'(bus.status), 32'h4);

        // One load, then starvation: the same words repeat with underrun flagged.
        tick(100);
        bus.status_clr = 1;
        strobe(1, 1, 24'h123456, 24'h654321);
        bus.status_clr = 0;
        wait_load();
        wait_load();
        check("starve_l0", 32'(last_l), 32'h123456);
        check("starve_underrun", 32'(bus.status[0]), 32'd1);
        wait_load();
        check("starve_l1", 32'(last_l), 32'h123456);
        check("starve_r1", 32'(last_r), 32'h654321);
        wait_load();
        check("starve_l2", 32'(last_l), 32'h123456);
        tick(50);
        clr_pulse();
        check("status_clr", 32'(bus.status), 32'h4);

        // Double write within one frame: newest wins, overrun flagged.
        strobe(1, 0, 24'h000001, '0);
        tick(10);
        strobe(1, 1, 24'h7FFFFF, 24'h0ABCDE);
        check("overrun_flag", 32'(bus.status), 32'h6);
        wait_load();
        wait_load();
        check("overrun_l", 32'(last_l), 32'h7FFFFF);
        check("overrun_r", 32'(last_r), 32'h0ABCDE);
        check("overrun_sticky", 32'(bus.status[1]), 32'd1);

        // Strobe coinciding with the frame load bypasses into the frame.
        clr_pulse();
        tick(508);
        strobe(1, 1, 24'h800000, 24'h000ABC);
        check("bypass_align", 32'(bus.sample_req), 32'd1);
        check("bypass_no_underrun", 32'(bus.status), 32'h4);
        tick(100);
        strobe(1, 1, 24'h111111, 24'h222222);
        wait_load();
        check("bypass_l", 32'(last_l), 32'h800000);
        check("bypass_r", 32'(last_r), 32'h000ABC);
        check("bypass_status", 32'(bus.status), 32'h4);

        // Abort at bc=40, then restart from a clean frame.
        strobe(1, 1, 24'hC00000, 24'h000001);
        tick(320);
        bus.audio_en = 0;
        tick(1);
        check("abort_pins", 32'({bus.bclk, bus.lrclk, bus.s_data}), 32'd0);
        check("abort_running", 32'(bus.status[2]), 32'd0);
        tick(5);
        bus.audio_en = 1;
        tick(1);
        check("restart_pins", 32'({bus.lrclk, bus.s_data, bus.sample_req}), 32'b001);
        tick(3);
        check("restart_bclk_low", 32'(bus.bclk), 32'd0);
        tick(1);
        check("restart_bclk_rise", 32'(bus.bclk), 32'd1);
        tick(4);
        check("restart_msb", 32'({bus.bclk, bus.s_data}), 32'b01);
        tick(8);
        check("restart_bit22", 32'(bus.s_data), 32'd1);
        tick(8);
        check("restart_bit21", 32'(bus.s_data), 32'd0);

        // Reset mid-frame with both sticky bits set.
        wait_load();
        check("restart_word", 32'(last_l), 32'hC00000);
        tick(50);
        strobe(1, 0, 24'h000001, '0);
        strobe(1, 0, 24'h000002, '0);
        check("pre_reset_status", 32'(bus.status), 32'h7);
        reset = 1;
        tick(1);
        check("midreset_pins", 32'({bus.bclk, bus.lrclk, bus.s_data, bus.sample_req}), 32'd0);
        check("midreset_status", 32'(bus.status), 32'd0);
        reset = 0;
        tick(1);
        check("post_reset_load", 32'({bus.sample_req, bus.status}), 32'h15);
        wait_load();
        wait_load();
        check("post_reset_l", 32'(last_l), 32'd0);
        check("post_reset_r", 32'(last_r), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
